sram_seq_macro: RTL and testbench

//  Parametrised single-port synchronous SRAM macro for the DMG SoC (HRAM/OAM/WRAM-class arrays).

---
 rtl/sram_seq_macro.sv | 139 +++++++++++++
 tb/tb_sram_seq_macro.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_seq_macro.sv
// sram_seq_macro
//   Single-port synchronous SRAM macro with an internal access sequencer.
//   Each accepted request runs PCH (precharge, PCH_CYCLES clocks) -> ACT
//   (wordline up) -> XFER (sense or masked write at the end of the cycle)
//   -> DONE (one-cycle ack). The row is addr[AW-1:log2(COLS)] and the column
//   is addr[log2(COLS)-1:0]. Array contents are never cleared by reset.
//
// Handshake: req is a level. It is sampled only in IDLE or DONE. When req=1
//   is seen there, we/addr/wdata/wmask are captured on that edge and stay
//   frozen until the access completes. Exactly one ack pulse (the DONE
//   cycle) follows every accepted request. Holding req high in DONE starts
//   the next access back-to-back.
//
// Ports
//   CLK, RESET        clock; synchronous active-high reset
//   req, we           request level; 1 = write, 0 = read
//   addr [AW]         word address
//   wdata, wmask      write data; per-bit write enable (1 = write that bit)
//   rdata [WIDTH]     sense latch, holds the last read result
//   ack               one-cycle completion pulse
//   busy              access in flight (PCH/ACT/XFER)
//   n_pch, wl_ena     precharge strobe (active low), wordline enable
//   state_dbg [3]     current sequencer state, for observability
module sram_seq_macro #(
  parameter int WIDTH      = 8,
  parameter int ROWS       = 32,
  parameter int COLS       = 4,
  parameter int PCH_CYCLES = 1,
  localparam int AW        = $clog2(ROWS * COLS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  output logic [WIDTH-1:0] rdata,
  output logic             ack,
  output logic             busy,
  output logic             n_pch,
  output logic             wl_ena,
  output logic [2:0]       state_dbg
);

  localparam int CBITS = $clog2(COLS);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW    = (PCH_CYCLES > 1) ? $clog2(PCH_CYCLES) : 1;
  localparam logic [AW-1:0] COL_MASK = AW'(COLS - 1);
  localparam logic [PW-1:0] PCH_LAST = PW'(PCH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PCH  = 3'd1,
    ACT  = 3'd2,
    XFER = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   pch_cnt, pch_cnt_d;
  logic            capture;

  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [WIDTH-1:0] wdata_q, wmask_q;

  logic [WIDTH-1:0] mem [ROWS][COLS];
  logic [RW-1:0]    row_sel;
  logic [CW-1:0]    col_sel;

  // Row/column decode of the frozen address; total because ROWS*COLS is a
  // power of two.
  assign row_sel = RW'(addr_q >> CBITS);
  assign col_sel = CW'(addr_q & COL_MASK);

  always_comb begin
    state_d   = state;
    pch_cnt_d = pch_cnt;
    capture   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (req) begin
          capture   = 1'b1;
          state_d   = PCH;
          pch_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      PCH: begin
        if (pch_cnt == PCH_LAST) state_d = ACT;
        else                     pch_cnt_d = pch_cnt + PW'(1);
      end
      ACT:     state_d = XFER;
      XFER:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      pch_cnt <= '0;
      rdata   <= '0;
    end else begin
      state   <= state_d;
      pch_cnt <= pch_cnt_d;
      if (state == XFER && !we_q) rdata <= mem[row_sel][col_sel];
    end
  end

  // Request capture; only meaningful once the FSM leaves IDLE/DONE, so it
  // needs no reset.
  always_ff @(posedge CLK) begin
    if (capture && !RESET) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
      wmask_q <= wmask;
    end
  end

  // Masked write driver. Reset on the XFER edge suppresses the commit.
  always_ff @(posedge CLK) begin
    if (!RESET && state == XFER && we_q)
      mem[row_sel][col_sel] <= (mem[row_sel][col_sel] & ~wmask_q) | (wdata_q & wmask_q);
  end

  // Outputs are pure decodes of the registered state, so they are glitch-free
  // relative to the clock and n_pch/wl_ena can never overlap.
  assign ack       = (state == DONE);
  assign busy      = (state == PCH) || (state == ACT) || (state == XFER);
  assign n_pch     = (state != PCH);
  assign wl_ena    = (state == ACT) || (state == XFER);
  assign state_dbg = state;

endmodule

// File: tb/tb_sram_seq_macro.sv
module tb_sram_seq_macro;

  logic       clk;
  logic       rst;
  logic       req1, req3;
  logic       we_s;
  logic [6:0] addr_s;
  logic [7:0] wdata_s, wmask_s;

  logic [7:0] rdata1, rdata3;
  logic       ack1, ack3, busy1, busy3, npch1, npch3, wl1, wl3;
  logic [2:0] st1, st3;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] wmask;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];
  vec_t ops[12];

  sram_seq_macro #(.WIDTH(8), .ROWS(32), .COLS(4), .PCH_CYCLES(1)) dut1 (
    .CLK(clk), .RESET(rst), .req(req1), .we(we_s), .addr(addr_s),
    .wdata(wdata_s), .wmask(wmask_s), .rdata(rdata1), .ack(ack1),
    .busy(busy1), .n_pch(npch1), .wl_ena(wl1), .state_dbg(st1)
  );

  sram_seq_macro #(.WIDTH(8), .ROWS(32), .COLS(4), .PCH_CYCLES(3)) dut3 (
    .CLK(clk), .RESET(rst), .req(req3), .we(we_s), .addr(addr_s),
    .wdata(wdata_s), .wmask(wmask_s), .rdata(rdata3), .ack(ack3),
    .busy(busy3), .n_pch(npch3), .wl_ena(wl3), .state_dbg(st3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // driver: one access on the selected instance (sel=1 -> PCH_CYCLES=3)
  task automatic do_access(input logic sel, input logic w, input logic [6:0] a,
                           input logic [7:0] d, input logic [7:0] m,
                           output int lat, output int pch_lo, output logic [7:0] rd);
    logic a_ack, a_npch, a_wl, a_busy;
    we_s = w; addr_s = a; wdata_s = d; wmask_s = m;
    if (sel) req3 = 1'b1; else req1 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0; req3 = 1'b0;
    // scramble inputs: the captured request must stay frozen
    we_s = 1'($urandom_range(0, 1)); addr_s = 7'($urandom_range(0, 127));
    wdata_s = 8'($urandom_range(0, 255)); wmask_s = 8'($urandom_range(0, 255));
    lat = 0;
    pch_lo = ((sel ? npch3 : npch1) == 1'b0) ? 1 : 0;
    a_ack = 1'b0;
    while (!a_ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      a_ack  = sel ? ack3 : ack1;
      a_npch = sel ? npch3 : npch1;
      a_wl   = sel ? wl3 : wl1;
      if (!a_npch) pch_lo++;
      if (!a_npch && a_wl) begin
        bad++; total++;
        $display("FAIL overlap: n_pch=0 wl_ena=1 at lat %0d", lat);
      end
    end
    if (!a_ack) begin
      bad++; total++;
      $display("FAIL ack_timeout: got=none want=ack within 20");
    end
    rd = sel ? rdata3 : rdata1;
    @(posedge clk); #1;
    a_ack  = sel ? ack3 : ack1;
    a_busy = sel ? busy3 : busy1;
    check("ack_one_cycle", {a_ack, a_busy}, 2'b00);
  endtask

  task automatic drive_op(input vec_t v);
    we_s = v.we; addr_s = v.addr; wdata_s = v.wdata; wmask_s = v.wmask;
  endtask

  initial begin
    int lat, pch_lo, nxt, done_k, last_ack;
    logic [7:0] rd;
    bit pending;

    req1 = 1'b0; req3 = 1'b0; we_s = 1'b0; addr_s = '0; wdata_s = '0; wmask_s = '0;
    rst = 1'b1;

    vecs[0]  = '{1'b1, 7'h05, 8'hA5, 8'hFF, 8'h00};
    vecs[1]  = '{1'b0, 7'h05, 8'h00, 8'h00, 8'hA5};
    vecs[2]  = '{1'b1, 7'h7F, 8'h3C, 8'hFF, 8'hA5};
    vecs[3]  = '{1'b1, 7'h7F, 8'hFF, 8'h0F, 8'hA5};
    vecs[4]  = '{1'b0, 7'h7F, 8'h00, 8'h00, 8'h3F};
    vecs[5]  = '{1'b1, 7'h05, 8'h00, 8'h00, 8'h3F};
    vecs[6]  = '{1'b0, 7'h05, 8'h00, 8'h00, 8'hA5};
    vecs[7]  = '{1'b1, 7'h40, 8'hAA, 8'hFF, 8'hA5};
    vecs[8]  = '{1'b1, 7'h40, 8'h55, 8'hF0, 8'hA5};
    vecs[9]  = '{1'b0, 7'h40, 8'h00, 8'h00, 8'h5A};
    vecs[10] = '{1'b1, 7'h7F, 8'h00, 8'hFF, 8'h5A};
    vecs[11] = '{1'b0, 7'h7F, 8'h00, 8'h00, 8'h00};

    ops[0]  = '{1'b1, 7'h00, 8'h1E, 8'hFF, 8'h00};
    ops[1]  = '{1'b0, 7'h00, 8'h00, 8'h00, 8'h1E};
    ops[2]  = '{1'b1, 7'h01, 8'h2D, 8'hFF, 8'h00};
    ops[3]  = '{1'b0, 7'h01, 8'h00, 8'h00, 8'h2D};
    ops[4]  = '{1'b1, 7'h02, 8'h3C, 8'hFF, 8'h00};
    ops[5]  = '{1'b0, 7'h02, 8'h00, 8'h00, 8'h3C};
    ops[6]  = '{1'b1, 7'h03, 8'h4B, 8'hFF, 8'h00};
    ops[7]  = '{1'b0, 7'h03, 8'h00, 8'h00, 8'h4B};
    ops[8]  = '{1'b0, 7'h00, 8'h00, 8'h00, 8'h1E};
    ops[9]  = '{1'b0, 7'h01, 8'h00, 8'h00, 8'h2D};
    ops[10] = '{1'b0, 7'h02, 8'h00, 8'h00, 8'h3C};
    ops[11] = '{1'b0, 7'h03, 8'h00, 8'h00, 8'h4B};

    // 1. reset then idle
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_outputs", {rdata1, ack1, busy1, npch1, wl1}, {8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    end

    // 2/3 + masked writes: table-driven single accesses
    for (int i = 0; i < 12; i++) begin
      do_access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, lat, pch_lo, rd);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_rdata", i), {24'h0, rd}, {24'h0, vecs[i].exp_rdata});
    end

    // 4. back-to-back under continuous req, same row, all columns
    for (int i = 0; i < 12; i++) if (!ops[i].we) exp_q.push_back(ops[i].exp_rdata);
    drive_op(ops[0]);
    req1 = 1'b1;
    @(posedge clk); #1;
    nxt = 1;
    drive_op(ops[1]);
    done_k = 0; last_ack = 0; pending = 1'b0;
    for (int cyc = 1; cyc <= 100 && done_k < 12; cyc++) begin
      @(posedge clk); #1;
      if (pending) begin
        nxt++;
        if (nxt < 12) drive_op(ops[nxt]);
        else          req1 = 1'b0;
        pending = 1'b0;
      end
      if (ack1) begin
        if (done_k > 0) check($sformatf("b2b_interval%0d", done_k), 32'(cyc - last_ack), 32'd4);
        if (!ops[done_k].we) check($sformatf("b2b_rdata%0d", done_k), {24'h0, rdata1}, {24'h0, exp_q.pop_front()});
        last_ack = cyc;
        done_k++;
        pending = 1'b1;
      end
    end
    req1 = 1'b0;
    check("b2b_count", 32'(done_k), 32'd12);
    @(posedge clk); #1;

    // 5. PCH_CYCLES=3 instance
    do_access(1'b1, 1'b0, 7'h05, 8'h00, 8'h00, lat, pch_lo, rd);
    check("pch3_lat", 32'(lat), 32'd5);
    check("pch3_npch_low", 32'(pch_lo), 32'd3);

    // 6. reset on the XFER edge must not commit the write
    do_access(1'b0, 1'b1, 7'h10, 8'h11, 8'hFF, lat, pch_lo, rd);
    we_s = 1'b1; addr_s = 7'h10; wdata_s = 8'hEE; wmask_s = 8'hFF;
    req1 = 1'b1;
    @(posedge clk); #1;          // accepted, PCH
    req1 = 1'b0;
    @(posedge clk); #1;          // ACT
    @(posedge clk); #1;          // XFER
    check("rst_xfer_state", {29'h0, st1}, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_xfer_outputs", {rdata1, ack1, busy1, npch1, wl1}, {8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_ack", {31'h0, ack1}, 32'd0);
    end
    do_access(1'b0, 1'b0, 7'h10, 8'h00, 8'h00, lat, pch_lo, rd);
    check("rst_xfer_read", {24'h0, rd}, 32'h11);

    // reset in DONE drops ack on the next cycle
    we_s = 1'b0; addr_s = 7'h05; req1 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("done_pre_reset_ack", {31'h0, ack1}, 32'd0);
    @(posedge clk); #1;
    check("done_ack", {31'h0, ack1}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("done_reset_ack", {rdata1, ack1, busy1}, {8'h00, 1'b0, 1'b0});
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
